// File: rtl/ibex_ex_issue_ctrl.sv
// rtl/ibex_ex_issue_ctrl.sv - EX issue/completion controller with multdiv watchdog and response register
module ibex_ex_issue_ctrl #(
    parameter int unsigned TagW      = 4,
    parameter int unsigned MdTimeout = 64,
    parameter bit          RV32M     = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_type_i,
    input  logic [TagW-1:0] req_tag_i,
    input  logic            flush_i,

    output logic            mult_en_o,
    output logic            div_en_o,
    output logic            multdiv_sel_o,
    output logic            multdiv_ready_id_o,
    input  logic            ex_valid_i,
    input  logic [31:0]     result_ex_i,

    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [31:0]     rsp_data_o,
    output logic [TagW-1:0] rsp_tag_o,

    output logic            busy_o,
    output logic            timeout_o,
    output logic [31:0]     md_cycles_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    // Watchdog fires on the idle cycle that finds the counter at MdTimeout-1
    localparam bit          WdEn   = (MdTimeout != 0);
    localparam logic [31:0] WdLast = WdEn ? 32'(MdTimeout - 1) : 32'd0;

    state_e            state_q, state_d;
    logic              kind_q, kind_d;          // 0: multiply, 1: divide
    logic [TagW-1:0]   tag_q, tag_d;
    logic [31:0]       wd_cnt_q, wd_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [TagW-1:0]   rsp_tag_q, rsp_tag_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       md_cycles_q, md_cycles_d;

    logic in_busy;
    logic rsp_free;
    logic req_is_md;
    logic accept;
    logic md_done;
    logic md_idle;
    logic wd_fire;
    logic capture;

    // Handshake and event decode; flush masks both acceptance and completion
    always_comb begin
        in_busy   = (state_q == MD_BUSY);
        rsp_free  = !rsp_valid_q || rsp_ready_i;
        req_is_md = RV32M && ((req_type_i == 2'b01) || (req_type_i == 2'b10));
        accept    = req_valid_i && !in_busy && !flush_i && rsp_free;
        md_done   = in_busy && !flush_i && ex_valid_i && rsp_free;
        md_idle   = in_busy && !flush_i && !ex_valid_i;
        wd_fire   = WdEn && md_idle && (wd_cnt_q == WdLast);
        capture   = (accept && !req_is_md) || md_done;
    end

    // Next-state for the FSM, watchdog, response register and busy-cycle counter
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        tag_d       = tag_q;
        wd_cnt_d    = wd_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        timeout_d   = wd_fire;
        md_cycles_d = md_cycles_q;

        case (state_q)
            IDLE: begin
                if (accept && req_is_md) begin
                    state_d  = MD_BUSY;
                    kind_d   = req_type_i[1];
                    tag_d    = req_tag_i;
                    wd_cnt_d = 32'd0;
                end
            end
            MD_BUSY: begin
                if (flush_i || md_done || wd_fire) begin
                    state_d = IDLE;
                end else if (md_idle) begin
                    wd_cnt_d = wd_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new capture overrides the drain of the previous response
        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = result_ex_i;
            rsp_tag_d   = md_done ? tag_q : req_tag_i;
        end else if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end

        if (in_busy && (md_cycles_q != 32'hFFFF_FFFF)) begin
            md_cycles_d = md_cycles_q + 32'd1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            kind_q      <= 1'b0;
            tag_q       <= '0;
            wd_cnt_q    <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_tag_q   <= '0;
            timeout_q   <= 1'b0;
            md_cycles_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            tag_q       <= tag_d;
            wd_cnt_q    <= wd_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            timeout_q   <= timeout_d;
            md_cycles_q <= md_cycles_d;
        end
    end

    // Enables are pure decodes of registered state so reset drops them at once
    always_comb begin
        req_ready_o        = !in_busy && !flush_i && rsp_free;
        mult_en_o          = in_busy && !kind_q;
        div_en_o           = in_busy && kind_q;
        multdiv_sel_o      = in_busy;
        busy_o             = in_busy;
        multdiv_ready_id_o = in_busy && rsp_free;
        rsp_valid_o        = rsp_valid_q;
        rsp_data_o         = rsp_data_q;
        rsp_tag_o          = rsp_tag_q;
        timeout_o          = timeout_q;
        md_cycles_o        = md_cycles_q;
    end

endmodule

// File: tb/tb_ibex_ex_issue_ctrl.sv
// tb/tb_ibex_ex_issue_ctrl.sv - self-checking bench for ibex_ex_issue_ctrl
module tb_ibex_ex_issue_ctrl;

    localparam int MDT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid;
    logic [1:0]  req_type;
    logic [3:0]  req_tag;
    logic        flush;
    logic        ex_valid;
    logic [31:0] result;
    logic        rsp_ready;

    logic        rdy [2];
    logic        men [2];
    logic        den [2];
    logic        sel [2];
    logic        mdrdy [2];
    logic        rsv [2];
    logic [31:0] dat [2];
    logic [3:0]  rtag [2];
    logic        bsy [2];
    logic        tmo [2];
    logic [31:0] mdc [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ibex_ex_issue_ctrl #(.TagW(4), .MdTimeout(MDT), .RV32M(1'b1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(rdy[0]), .req_type_i(req_type), .req_tag_i(req_tag),
        .flush_i(flush), .mult_en_o(men[0]), .div_en_o(den[0]), .multdiv_sel_o(sel[0]),
        .multdiv_ready_id_o(mdrdy[0]), .ex_valid_i(ex_valid), .result_ex_i(result),
        .rsp_valid_o(rsv[0]), .rsp_ready_i(rsp_ready), .rsp_data_o(dat[0]), .rsp_tag_o(rtag[0]),
        .busy_o(bsy[0]), .timeout_o(tmo[0]), .md_cycles_o(mdc[0])
    );

    ibex_ex_issue_ctrl #(.TagW(4), .MdTimeout(MDT), .RV32M(1'b0)) u_dut_nom (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(rdy[1]), .req_type_i(req_type), .req_tag_i(req_tag),
        .flush_i(flush), .mult_en_o(men[1]), .div_en_o(den[1]), .multdiv_sel_o(sel[1]),
        .multdiv_ready_id_o(mdrdy[1]), .ex_valid_i(ex_valid), .result_ex_i(result),
        .rsp_valid_o(rsv[1]), .rsp_ready_i(rsp_ready), .rsp_data_o(dat[1]), .rsp_tag_o(rtag[1]),
        .busy_o(bsy[1]), .timeout_o(tmo[1]), .md_cycles_o(mdc[1])
    );

    typedef struct packed {
        logic        rv;
        logic [1:0]  ty;
        logic [3:0]  tg;
        logic        fl;
        logic        exv;
        logic [31:0] res;
        logic        rr;
        logic        e_rdy;
        logic        e_v;
        logic [31:0] e_data;
        logic [3:0]  e_tag;
        logic        e_men;
        logic        e_den;
        logic        e_mdrdy;
        logic [31:0] e_mdc;
    } vec_t;

    vec_t tbl [28];

    // Behavioural reference state, one slot per instance (0: RV32M=1, 1: RV32M=0)
    logic        m_busy [2];
    logic        m_div [2];
    logic [3:0]  m_tag [2];
    int          m_idle [2];
    logic        m_rv [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_rt [2];
    logic        m_to [2];
    longint      m_mdc [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rv, input logic [1:0] ty, input logic [3:0] tg,
                         input logic fl, input logic exv, input logic [31:0] res, input logic rr);
        req_valid = rv;
        req_type  = ty;
        req_tag   = tg;
        flush     = fl;
        ex_valid  = exv;
        result    = res;
        rsp_ready = rr;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_div[k] = 1'b0; m_tag[k] = '0; m_idle[k] = 0;
            m_rv[k] = 1'b0; m_dat[k] = '0; m_rt[k] = '0; m_to[k] = 1'b0; m_mdc[k] = 0;
        end
    endtask

    task automatic model_check(input int k);
        logic free;
        free = !m_rv[k] || rsp_ready;
        chk("rand_req_ready", rdy[k], !m_busy[k] && !flush && free);
        chk("rand_rsp_valid", rsv[k], m_rv[k]);
        if (m_rv[k]) begin
            chk("rand_rsp_data", dat[k], m_dat[k]);
            chk("rand_rsp_tag", rtag[k], m_rt[k]);
        end
        chk("rand_mult_en", men[k], m_busy[k] && !m_div[k]);
        chk("rand_div_en", den[k], m_busy[k] && m_div[k]);
        chk("rand_sel", sel[k], m_busy[k]);
        chk("rand_busy", bsy[k], m_busy[k]);
        chk("rand_md_ready", mdrdy[k], m_busy[k] && free);
        chk("rand_timeout", tmo[k], m_to[k]);
        chk("rand_md_cycles", mdc[k], 32'(m_mdc[k]));
    endtask

    task automatic model_step(input int k);
        logic        free, cap, nto, is_md;
        logic [31:0] cd;
        logic [3:0]  ct;
        free  = !m_rv[k] || rsp_ready;
        is_md = (k == 0) && (req_type == 2'd1 || req_type == 2'd2);
        cap = 1'b0; nto = 1'b0; cd = '0; ct = '0;
        if (m_busy[k]) begin
            if (m_mdc[k] < 64'hFFFF_FFFF) m_mdc[k]++;
            if (flush) begin
                m_busy[k] = 1'b0;
            end else if (ex_valid) begin
                if (free) begin
                    cap = 1'b1; cd = result; ct = m_tag[k]; m_busy[k] = 1'b0;
                end
            end else begin
                m_idle[k]++;
                if (m_idle[k] == MDT) begin
                    m_busy[k] = 1'b0; nto = 1'b1;
                end
            end
        end else if (req_valid && !flush && free) begin
            if (is_md) begin
                m_busy[k] = 1'b1; m_div[k] = req_type[1]; m_tag[k] = req_tag; m_idle[k] = 0;
            end else begin
                cap = 1'b1; cd = result; ct = req_tag;
            end
        end
        if (cap) begin
            m_rv[k] = 1'b1; m_dat[k] = cd; m_rt[k] = ct;
        end else if (m_rv[k] && rsp_ready) begin
            m_rv[k] = 1'b0;
        end
        m_to[k] = nto;
    endtask

    initial begin
        //            rv ty  tg  fl ex res            rr  rdy v  data           tag men den mdr mdc
        tbl[0]  = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b0,32'h0,        4'd0,1'b0,1'b0,1'b0,32'd0};
        tbl[1]  = '{1'b1,2'd0,4'd1, 1'b0,1'b0,32'h10,       1'b1, 1'b1,1'b0,32'h0,        4'd0,1'b0,1'b0,1'b0,32'd0};
        tbl[2]  = '{1'b1,2'd0,4'd2, 1'b0,1'b0,32'h11,       1'b1, 1'b1,1'b1,32'h10,       4'd1,1'b0,1'b0,1'b0,32'd0};
        tbl[3]  = '{1'b1,2'd0,4'd3, 1'b0,1'b0,32'h12,       1'b1, 1'b1,1'b1,32'h11,       4'd2,1'b0,1'b0,1'b0,32'd0};
        tbl[4]  = '{1'b1,2'd0,4'd4, 1'b0,1'b0,32'h13,       1'b1, 1'b1,1'b1,32'h12,       4'd3,1'b0,1'b0,1'b0,32'd0};
        tbl[5]  = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b1,32'h13,       4'd4,1'b0,1'b0,1'b0,32'd0};
        tbl[6]  = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,32'h0,        4'd0,1'b0,1'b0,1'b0,32'd0};
        tbl[7]  = '{1'b1,2'd1,4'd5, 1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,32'h0,        4'd0,1'b0,1'b0,1'b0,32'd0};
        tbl[8]  = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b1, 1'b0,1'b0,32'h0,        4'd0,1'b1,1'b0,1'b1,32'd0};
        tbl[9]  = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b1, 1'b0,1'b0,32'h0,        4'd0,1'b1,1'b0,1'b1,32'd1};
        tbl[10] = '{1'b0,2'd0,4'd0, 1'b0,1'b1,32'hDEADBEEF, 1'b0, 1'b0,1'b0,32'h0,        4'd0,1'b1,1'b0,1'b1,32'd2};
        tbl[11] = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b1,32'hDEADBEEF, 4'd5,1'b0,1'b0,1'b0,32'd3};
        tbl[12] = '{1'b1,2'd2,4'd6, 1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b1,32'hDEADBEEF, 4'd5,1'b0,1'b0,1'b0,32'd3};
        tbl[13] = '{1'b1,2'd2,4'd6, 1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b1,32'hDEADBEEF, 4'd5,1'b0,1'b0,1'b0,32'd3};
        tbl[14] = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b0,32'h0,        4'd0,1'b0,1'b1,1'b1,32'd3};
        tbl[15] = '{1'b0,2'd0,4'd0, 1'b0,1'b1,32'h55,       1'b0, 1'b0,1'b0,32'h0,        4'd0,1'b0,1'b1,1'b1,32'd4};
        tbl[16] = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b1,32'h55,       4'd6,1'b0,1'b0,1'b0,32'd5};
        tbl[17] = '{1'b1,2'd2,4'd7, 1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,32'h0,        4'd0,1'b0,1'b0,1'b0,32'd5};
        tbl[18] = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b1, 1'b0,1'b0,32'h0,        4'd0,1'b0,1'b1,1'b1,32'd5};
        tbl[19] = '{1'b1,2'd0,4'd8, 1'b1,1'b1,32'h99,       1'b1, 1'b0,1'b0,32'h0,        4'd0,1'b0,1'b1,1'b1,32'd6};
        tbl[20] = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,32'h0,        4'd0,1'b0,1'b0,1'b0,32'd7};
        tbl[21] = '{1'b1,2'd0,4'd8, 1'b1,1'b0,32'h77,       1'b1, 1'b0,1'b0,32'h0,        4'd0,1'b0,1'b0,1'b0,32'd7};
        tbl[22] = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,32'h0,        4'd0,1'b0,1'b0,1'b0,32'd7};
        tbl[23] = '{1'b1,2'd3,4'd9, 1'b0,1'b0,32'hA5,       1'b1, 1'b1,1'b0,32'h0,        4'd0,1'b0,1'b0,1'b0,32'd7};
        tbl[24] = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b1,32'hA5,       4'd9,1'b0,1'b0,1'b0,32'd7};
        tbl[25] = '{1'b1,2'd0,4'd10,1'b0,1'b0,32'hBB,       1'b0, 1'b0,1'b1,32'hA5,       4'd9,1'b0,1'b0,1'b0,32'd7};
        tbl[26] = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b1,32'hA5,       4'd9,1'b0,1'b0,1'b0,32'd7};
        tbl[27] = '{1'b0,2'd0,4'd0, 1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b0,32'h0,        4'd0,1'b0,1'b0,1'b0,32'd7};

        drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_req_ready", rdy[0], 1'b1);
        chk("reset_rsp_valid", rsv[0], 1'b0);
        chk("reset_busy", bsy[0], 1'b0);
        chk("reset_md_cycles", mdc[0], 32'd0);
        chk("reset_timeout", tmo[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: ALU burst, MULT, blocked accept, DIV, flush, type 11
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            drive(tbl[i].rv, tbl[i].ty, tbl[i].tg, tbl[i].fl, tbl[i].exv, tbl[i].res, tbl[i].rr);
            #1;
            chk($sformatf("tbl%0d_req_ready", i), rdy[0], tbl[i].e_rdy);
            chk($sformatf("tbl%0d_rsp_valid", i), rsv[0], tbl[i].e_v);
            if (tbl[i].e_v) begin
                chk($sformatf("tbl%0d_rsp_data", i), dat[0], tbl[i].e_data);
                chk($sformatf("tbl%0d_rsp_tag", i), rtag[0], tbl[i].e_tag);
            end
            chk($sformatf("tbl%0d_mult_en", i), men[0], tbl[i].e_men);
            chk($sformatf("tbl%0d_div_en", i), den[0], tbl[i].e_den);
            chk($sformatf("tbl%0d_busy", i), bsy[0], tbl[i].e_men | tbl[i].e_den);
            chk($sformatf("tbl%0d_sel", i), sel[0], tbl[i].e_men | tbl[i].e_den);
            chk($sformatf("tbl%0d_md_ready", i), mdrdy[0], tbl[i].e_mdrdy);
            chk($sformatf("tbl%0d_md_cycles", i), mdc[0], tbl[i].e_mdc);
        end

        // Watchdog: MULT with ex_valid stuck low aborts after MDT busy cycles
        @(negedge clk);
        drive(1'b1, 2'd1, 4'd3, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b1);
            #1;
            chk($sformatf("wd%0d_timeout", c), tmo[0], (c == MDT + 1));
            chk($sformatf("wd%0d_mult_en", c), men[0], (c <= MDT));
            chk($sformatf("wd%0d_rsp_valid", c), rsv[0], 1'b0);
        end
        chk("wd_md_cycles", mdc[0], 32'd7 + MDT);
        chk("wd_req_ready", rdy[0], 1'b1);

        // Reset in the middle of a DIV
        @(negedge clk);
        drive(1'b1, 2'd2, 4'd2, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        end
        #1;
        chk("rst_pre_div_en", den[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_div_en", den[0], 1'b0);
        chk("rst_busy", bsy[0], 1'b0);
        chk("rst_rsp_valid", rsv[0], 1'b0);
        chk("rst_md_cycles", mdc[0], 32'd0);
        chk("rst_req_ready", rdy[0], 1'b1);
        @(negedge clk);
        drive(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic against the reference model, both RV32M settings
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            drive(($urandom % 4) != 0, 2'($urandom % 4), 4'($urandom), ($urandom % 16) == 0,
                  ($urandom % 6) == 0, $urandom, ($urandom % 3) != 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                model_check(k);
                model_step(k);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ibex_ex_issue_ctrl.md
# ibex_ex_issue_ctrl

Issue and completion controller for the execution block. Accepts one operation at a time from ID and classifies it as a single-cycle ALU op or a multi-cycle multiply/divide. It drives the multiplier/divider enables and the ID-ready handshake, and captures the EX result into a one-entry response register toward writeback. It also supports flush, a multdiv watchdog timeout, and a saturating multdiv busy-cycle counter.

## Interface
- TagW, 4: width of the request/response tag.
- MdTimeout, 64: number of cycles in MD_BUSY with ex_valid_i=0 before abort; 0 disables the watchdog.
- RV32M, 1: when 0, MULT/DIV requests complete as ALU ops and no enable is ever asserted.

Ports. The block has one clock; reset is asynchronous and active-low (clk_i, rst_ni).
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&&ready
- req_type_i  in  2  00 ALU, 01 MULT, 10 DIV, 11 treated as ALU
- req_tag_i  in  TagW  request tag
- flush_i  in  1  kill in-flight multdiv op, block acceptance this cycle
- mult_en_o  out  1  to EX mult_en_i
- div_en_o  out  1  to EX div_en_i
- multdiv_sel_o  out  1  to EX multdiv_sel_i; ALU adder owned by multdiv
- multdiv_ready_id_o  out  1  to EX multdiv_ready_id_i
- ex_valid_i  in  1  EX result valid
- result_ex_i  in  32  EX result
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  32  captured result
- rsp_tag_o  out  TagW  tag of captured result
- busy_o  out  1  multdiv op in flight; upstream holds operands stable while set
- timeout_o  out  1  one-cycle pulse on watchdog abort
- md_cycles_o  out  32  saturating count of MD_BUSY cycles

## Operation
- States are IDLE and MD_BUSY. The response register (rsp_valid_o, rsp_data_o, rsp_tag_o) is independent of the state.
- rsp_free = !rsp_valid_o || rsp_ready_i.
- req_ready_o = (state==IDLE) && !flush_i && rsp_free.
- Accept ALU/type 11, or MULT/DIV when RV32M=0:
  - enables stay 0.
  - result_ex_i is captured the same cycle, with rsp_tag_o=req_tag_i.
  - State stays IDLE.
- Accept MULT/DIV with RV32M=1:
  - Latch the op kind and tag.
  - Transition to MD_BUSY.
  - Clear the watchdog counter.
- In MD_BUSY:
  - mult_en_o or div_en_o is 1 according to the latched kind.
  - multdiv_sel_o=1 and busy_o=1.
  - multdiv_ready_id_o = rsp_free.
- Completion in MD_BUSY: when ex_valid_i && rsp_free, capture result_ex_i with the latched tag and go to IDLE.
- Flush in MD_BUSY: go to IDLE the next cycle with no response. Flush takes priority over completion in the same cycle. A response already in the register is kept.
- Watchdog:
  - The counter increments on MD_BUSY cycles with ex_valid_i=0.
  - When it reaches MdTimeout-1 in such a cycle, pulse timeout_o next cycle, go to IDLE, and produce no response.
  - Cycles with ex_valid_i=1 but the response register full do not count.
- Response register:
  - Cleared when rsp_ready_i is high while rsp_valid_o is high, unless a new capture occurs the same cycle; capture wins.
- md_cycles_o increments every cycle in MD_BUSY and saturates at 32'hFFFF_FFFF.
- Reset values:
  - State is IDLE.
  - All outputs are 0, except req_ready_o, which is 1 combinationally after reset because rsp_free=1.

## Timing
- ALU: accept at cycle N; rsp_valid_o=1 at N+1.
- MULT/DIV: accept at N; enables are high from N+1. If ex_valid_i is seen at cycle M with rsp_free, rsp_valid_o=1 at M+1 and the enables are low at M+1.
- Back-to-back ALU ops with rsp_ready_i=1 sustain one op per cycle.
- The enables are registered-state decodes. multdiv_ready_id_o and req_ready_o are combinational from rsp_ready_i.
- Reset mid-operation: asynchronous return to IDLE. The enables drop immediately and no response is produced.

## Test plan
- ALU burst: 4 ALU reqs with tags 1..4, result_ex_i=0x10..0x13, rsp_ready_i=1 -> rsp on 4 consecutive cycles, data 0x10..0x13, tags 1..4, req_ready_o never low.
- MULT: accept with tag 5, ex_valid_i=1 on the third MD_BUSY cycle with result 0xDEADBEEF -> mult_en_o high for 3 cycles, rsp_data_o=0xDEADBEEF with tag 5 one cycle later, md_cycles_o=3.
- Backpressure: DIV completes while rsp_valid_o is held with rsp_ready_i=0 -> multdiv_ready_id_o=0 and state holds. Raise rsp_ready_i -> old rsp drains and DIV result is captured that cycle.
- Flush: flush_i on the second DIV cycle together with ex_valid_i=1 -> no response, div_en_o low next cycle, req_ready_o=0 during the flush cycle.
- Watchdog: MdTimeout=8, MULT with ex_valid_i stuck at 0 -> timeout_o pulses exactly once, 8 cycles after entering MD_BUSY; state returns to IDLE; no response.
- Reset mid-DIV: assert rst_ni low asynchronously -> div_en_o and busy_o are 0 immediately, rsp_valid_o=0, md_cycles_o=0.
